// File: rtl/fpu_fmt_pkg.sv
// Shared IEEE-754 format constants and the FSM state type for the FP32/FP64 conversion units.
package fpu_fmt_pkg;

    localparam int unsigned F32_EXP_W = 8;
    localparam int unsigned F32_FRA_W = 23;
    localparam int unsigned F64_EXP_W = 11;
    localparam int unsigned F64_FRA_W = 52;
    localparam int unsigned F32_BIAS  = 127;
    localparam int unsigned F64_BIAS  = 1023;
    localparam int unsigned REBIAS    = F64_BIAS - F32_BIAS;

    localparam logic [63:0] F64_POS_INF = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] F64_QNAN    = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fpu_fp32_classify.sv
// Combinational binary32 operand classifier, shared by the 32->64 and 64->32 conversion paths.
module fpu_fp32_classify
    import fpu_fmt_pkg::*;
(
    input  logic [31:0] src_i,
    output logic        is_zero_o,
    output logic        is_sub_o,
    output logic        is_norm_o,
    output logic        is_inf_o,
    output logic        is_nan_o,
    output logic        is_snan_o
);

    logic [F32_EXP_W-1:0] exp_w;
    logic [F32_FRA_W-1:0] fra_w;
    logic                 exp_min_w;
    logic                 exp_max_w;
    logic                 fra_zero_w;

    assign exp_w      = src_i[30:23];
    assign fra_w      = src_i[22:0];
    assign exp_min_w  = (exp_w == '0);
    assign exp_max_w  = (exp_w == '1);
    assign fra_zero_w = (fra_w == '0);

    assign is_zero_o  = exp_min_w & fra_zero_w;
    assign is_sub_o   = exp_min_w & ~fra_zero_w;
    assign is_norm_o  = ~exp_min_w & ~exp_max_w;
    assign is_inf_o   = exp_max_w & fra_zero_w;
    assign is_nan_o   = exp_max_w & ~fra_zero_w;
    // Quiet bit clear on a NaN marks it as signalling.
    assign is_snan_o  = exp_max_w & ~fra_zero_w & ~fra_w[22];

endmodule

// File: rtl/fpu_fp32_to_fp64.sv
// binary32 -> binary64 widening unit; subnormals are renormalised one bit per clock.
module fpu_fp32_to_fp64
    import fpu_fmt_pkg::*;
#(
    parameter bit DENORM_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_dst,
    output logic        out_invalid
);

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    // Only the fraction bits are kept: the leading zero of {1'b0, f} is implicit.
    logic [22:0] man_q, man_d;
    logic [10:0] exp_q, exp_d;
    logic [63:0] dst_q, dst_d;
    logic        inv_q, inv_d;

    logic        cls_zero, cls_sub, cls_norm, cls_inf, cls_nan, cls_snan;
    logic [63:0] direct_res;
    logic [22:0] man_sh;
    logic [10:0] exp_dec;

    fpu_fp32_classify u_classify (
        .src_i     (in_src),
        .is_zero_o (cls_zero),
        .is_sub_o  (cls_sub),
        .is_norm_o (cls_norm),
        .is_inf_o  (cls_inf),
        .is_nan_o  (cls_nan),
        .is_snan_o (cls_snan)
    );

    always_comb begin
        direct_res = {in_src[31], 63'b0};
        if (cls_norm) begin
            direct_res = {in_src[31], {3'b000, in_src[30:23]} + 11'(REBIAS), in_src[22:0], 29'b0};
        end else if (cls_inf) begin
            direct_res = {in_src[31], F64_POS_INF[62:0]};
        end else if (cls_nan) begin
            direct_res = {in_src[31], F64_QNAN[62:51], in_src[21:0], 29'b0};
        end else if (cls_zero || cls_sub) begin
            direct_res = {in_src[31], 63'b0};
        end
    end

    assign man_sh  = {man_q[21:0], 1'b0};
    assign exp_dec = exp_q - 11'd1;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        man_d   = man_q;
        exp_d   = exp_q;
        dst_d   = dst_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = in_src[31];
                    if (DENORM_EN && cls_sub) begin
                        man_d   = in_src[22:0];
                        exp_d   = 11'(REBIAS + 1);
                        state_d = ST_NORM;
                    end else begin
                        dst_d   = direct_res;
                        inv_d   = cls_snan;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_NORM: begin
                man_d = man_sh;
                exp_d = exp_dec;
                // The bit about to become the hidden one: this shift completes normalisation.
                if (man_q[22]) begin
                    dst_d   = {sign_q, exp_dec, man_sh, 29'b0};
                    inv_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            man_q   <= '0;
            exp_q   <= '0;
            dst_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            man_q   <= man_d;
            exp_q   <= exp_d;
            dst_q   <= dst_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_dst     = dst_q;
    assign out_invalid = inv_q;

endmodule
